// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fp_mult_pkg;

    // Control states of the multiplier sequencer
    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ROUND,
        SPECIAL,
        DONE
    } state_e;

    // Operand classification; exp==0 is always treated as zero (flush-to-zero)
    typedef enum logic [2:0] {
        ZERO,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } op_class_e;

    function automatic int calc_sig_w(input int man_w);
        return man_w + 1;
    endfunction

    function automatic int calc_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int calc_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Classify an operand from pre-reduced exponent/fraction properties
    function automatic op_class_e classify(input logic exp_ones, input logic exp_zero,
                                           input logic frac_zero, input logic frac_msb);
        op_class_e c;
        if (exp_zero)
            c = ZERO;
        else if (!exp_ones)
            c = NORMAL;
        else if (frac_zero)
            c = INF;
        else if (frac_msb)
            c = QNAN;
        else
            c = SNAN;
        return c;
    endfunction

endpackage

// File: rtl/fp_mult_param_sig_mult_seq.sv
// Iterative shift-add significand multiplier, SIG_BITS_PER_CYC multiplier bits per cycle.
module fp_sig_mult_seq #(
    parameter int SIG_W            = 24,
    parameter int SIG_BITS_PER_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [SIG_W-1:0]     multiplicand,
    input  logic [SIG_W-1:0]     multiplier,
    output logic [2*SIG_W-1:0]   product,
    output logic                 done
);
    localparam int N     = SIG_W / SIG_BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * SIG_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [SIG_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // done marks the cycle in which the final iteration is retired; acc_q is final after it
    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_q;

    // Load operands on start, otherwise retire the low multiplier bits into the accumulator
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = PW'(multiplicand);
            mplier_d = multiplier;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            for (int j = 0; j < SIG_BITS_PER_CYC; j++) begin
                if (mplier_q[j])
                    acc_d = acc_d + (mcand_q << j);
            end
            mcand_d  = mcand_q << SIG_BITS_PER_CYC;
            mplier_d = mplier_q >> SIG_BITS_PER_CYC;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done)
                busy_d = 1'b0;
        end
    end

    // Iteration state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/fp_mult_param.sv
// Handshaked parametrised FP multiplier: specials, RNE rounding, FTZ in/out, saturation flags.
module fp_mult_param
    import fp_mult_pkg::*;
#(
    parameter int EXP_W            = 8,
    parameter int MAN_W            = 23,
    parameter int SIG_BITS_PER_CYC = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     product,
    output logic [3:0]               flags
);
    localparam int SIG_W   = calc_sig_w(MAN_W);
    localparam int BIAS    = calc_bias(EXP_W);
    localparam int EXP_MAX = calc_exp_max(EXP_W);
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int EW      = EXP_W + 2;
    localparam int PW      = 2 * SIG_W;
    localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);
    localparam logic [W-1:0] QNAN_CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    product_q, product_d;
    logic [3:0]      flags_q, flags_d;
    logic            mul_start, mul_done;
    logic [PW-1:0]   mul_product;
    logic            sign_r;
    op_class_e       cls_a, cls_b, cls_in_a, cls_in_b;
    logic [W-1:0]    spec_product, round_product;
    logic [3:0]      spec_flags, round_flags;
    logic signed [EW-1:0] ea, eb, e_base, e_norm, e_fin;
    logic [PW-1:0]   p_norm;
    logic [SIG_W-1:0] kept;
    logic            guard, sticky, rnd_up, carry;
    logic [MAN_W-1:0] frac_r;

    function automatic op_class_e class_of(input logic [W-1:0] x);
        return classify(&x[W-2 -: EXP_W], ~|x[W-2 -: EXP_W], ~|x[MAN_W-1:0], x[MAN_W-1]);
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign flags     = flags_q;
    assign sign_r    = a_q[W-1] ^ b_q[W-1];
    assign cls_in_a  = class_of(a);
    assign cls_in_b  = class_of(b);

    fp_sig_mult_seq #(
        .SIG_W            (SIG_W),
        .SIG_BITS_PER_CYC (SIG_BITS_PER_CYC)
    ) u_sig_mult (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (mul_start),
        .multiplicand ({1'b1, a[MAN_W-1:0]}),
        .multiplier   ({1'b1, b[MAN_W-1:0]}),
        .product      (mul_product),
        .done         (mul_done)
    );

    // Special-operand result: NaN propagation first, then Inf x 0, Inf, zero
    always_comb begin
        cls_a        = class_of(a_q);
        cls_b        = class_of(b_q);
        spec_product = {sign_r, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        spec_flags   = '0;
        if (cls_a == QNAN || cls_a == SNAN || cls_b == QNAN || cls_b == SNAN) begin
            spec_product  = QNAN_CANON;
            spec_flags[3] = (cls_a == SNAN) || (cls_b == SNAN);
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            spec_product  = QNAN_CANON;
            spec_flags[3] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            spec_product = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Normalise, round to nearest even and saturate the significand product
    always_comb begin
        ea       = EW'(a_q[W-2 -: EXP_W]);
        eb       = EW'(b_q[W-2 -: EXP_W]);
        e_base   = ea + eb - BIAS_S;
        p_norm   = mul_product[PW-1] ? mul_product : (mul_product << 1);
        e_norm   = e_base + EW'(mul_product[PW-1]);
        kept     = p_norm[PW-1 -: SIG_W];
        guard    = p_norm[SIG_W-1];
        sticky   = |p_norm[SIG_W-2:0];
        rnd_up   = guard & (kept[0] | sticky);
        carry    = rnd_up & (&kept);
        frac_r   = kept[MAN_W-1:0] + MAN_W'(rnd_up);
        e_fin    = e_norm + EW'(carry);
        round_product = {sign_r, e_fin[EXP_W-1:0], frac_r};
        round_flags   = {3'b000, guard | sticky};
        if (e_fin >= EXP_MAX_S) begin
            round_product = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_flags   = 4'b0101;
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            round_product = {sign_r, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            round_flags   = 4'b0011;
        end
    end

    // Sequencer next-state and datapath capture
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    if (cls_in_a != NORMAL || cls_in_b != NORMAL) begin
                        state_d = SPECIAL;
                    end else begin
                        state_d   = MUL;
                        mul_start = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_done)
                    state_d = ROUND;
            end
            ROUND: begin
                product_d = round_product;
                flags_d   = round_flags;
                state_d   = DONE;
            end
            SPECIAL: begin
                product_d = spec_product;
                flags_d   = spec_flags;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_param.sv
// Scoreboard bench for fp_mult_param: single precision, 4 bits/cycle, and double precision.
module tb_fp_mult_param;

   typedef struct {
      logic [63:0] p;
      logic [3:0]  f;
      int          lat;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [2:0]  in_valid;
   logic [2:0]  out_ready;
   logic [2:0]  in_ready;
   logic [2:0]  out_valid;
   logic [31:0] a0, b0, a4, b4;
   logic [63:0] a64, b64;
   logic [31:0] p0, p4;
   logic [63:0] p64;
   logic [3:0]  f0, f4, f64;
   logic [63:0] prodW [3];
   logic [3:0]  flagsW [3];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb [3][$];

   fp_mult_param #(.EXP_W(8), .MAN_W(23), .SIG_BITS_PER_CYC(1)) u0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a0), .b(b0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .product(p0), .flags(f0));

   fp_mult_param #(.EXP_W(8), .MAN_W(23), .SIG_BITS_PER_CYC(4)) u4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a4), .b(b4), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .product(p4), .flags(f4));

   fp_mult_param #(.EXP_W(11), .MAN_W(52), .SIG_BITS_PER_CYC(1)) u64 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a64), .b(b64), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .product(p64), .flags(f64));

   // Present the three units uniformly to the monitor
   always_comb begin
      prodW[0] = {32'h0, p0};
      prodW[1] = {32'h0, p4};
      prodW[2] = p64;
      flagsW[0] = f0;
      flagsW[1] = f4;
      flagsW[2] = f64;
   end

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter used for latency measurement
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Drive operands on unit u and hold in_valid until accepted
   task automatic issueRaw(input int u, input logic [63:0] ta, input logic [63:0] tbv);
      bit got = 0;
      int guard = 0;
      @(posedge clk); #1;
      case (u)
         0: begin a0 = ta[31:0]; b0 = tbv[31:0]; end
         1: begin a4 = ta[31:0]; b4 = tbv[31:0]; end
         default: begin a64 = ta; b64 = tbv; end
      endcase
      in_valid[u] = 1'b1;
      while (!got && guard < 500) begin
         @(negedge clk);
         got = in_ready[u];
         @(posedge clk); #1;
         guard++;
      end
      in_valid[u] = 1'b0;
      if (!got) checkOutput($sformatf("u%0d accept timeout", u), 64'd0, 64'd1);
   endtask

   task automatic applyStimulus(input int u, input logic [63:0] ta, input logic [63:0] tbv,
                                input logic [63:0] ep, input logic [3:0] ef, input int el);
      exp_t e;
      e.p = ep; e.f = ef; e.lat = el;
      sb[u].push_back(e);
      issueRaw(u, ta, tbv);
   endtask

   task automatic drainAll();
      int guard = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size() != 0 || in_ready != 3'b111) && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("drain timeout", 64'(guard >= 3000), 64'd0);
   endtask

   // Monitor: latency on out_valid rise (accept edge counts as cycle 1), data on transfer
   initial begin
      int accCyc [3];
      bit prevValid [3];
      exp_t e;
      for (int u = 0; u < 3; u++) begin accCyc[u] = 0; prevValid[u] = 0; end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 3; u++) begin
            if (!reset_n) begin
               prevValid[u] = 0;
            end else begin
               if (in_valid[u] && in_ready[u]) accCyc[u] = cyc + 1;
               if (out_valid[u] && !prevValid[u]) begin
                  if (sb[u].size() == 0)
                     checkOutput($sformatf("u%0d unexpected out_valid", u), 64'd1, 64'd0);
                  else if (sb[u][0].lat != 0)
                     checkOutput($sformatf("u%0d latency", u), 64'(cyc - accCyc[u] + 1), 64'(sb[u][0].lat));
               end
               if (out_valid[u] && out_ready[u] && sb[u].size() != 0) begin
                  e = sb[u].pop_front();
                  checkOutput($sformatf("u%0d product", u), prodW[u], e.p);
                  checkOutput($sformatf("u%0d flags", u), 64'(flagsW[u]), 64'(e.f));
               end
               prevValid[u] = out_valid[u];
            end
         end
      end
   end

   // Watchdog so the run always ends with a summary
   initial begin
      #2000000;
      bad++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Directed stimulus
   initial begin
      reset_n = 1'b0; in_valid = '0; out_ready = '1;
      a0 = '0; b0 = '0; a4 = '0; b4 = '0; a64 = '0; b64 = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 64'(in_ready), 64'h7);
      checkOutput("reset out_valid", 64'(out_valid), 64'h0);
      checkOutput("reset product", prodW[2] | prodW[0], 64'h0);
      checkOutput("reset flags", 64'(flagsW[0]), 64'h0);
      reset_n = 1'b1;

      // Single precision, one bit per cycle
      applyStimulus(0, 64'h3FC00000, 64'h40000000, 64'h40400000, 4'b0000, 26);
      applyStimulus(0, 64'h3F800001, 64'h3FC00000, 64'h3FC00002, 4'b0001, 26);
      applyStimulus(0, 64'h3F800001, 64'h3F800001, 64'h3F800002, 4'b0001, 26);
      applyStimulus(0, 64'h3F800003, 64'h3FC00000, 64'h3FC00004, 4'b0001, 26);
      applyStimulus(0, 64'hC0400000, 64'h40000000, 64'hC0C00000, 4'b0000, 26);
      applyStimulus(0, 64'h7F800000, 64'h00000000, 64'h7FC00000, 4'b1000, 2);
      applyStimulus(0, 64'hFF800000, 64'h40000000, 64'hFF800000, 4'b0000, 2);
      applyStimulus(0, 64'h7F800001, 64'h3F800000, 64'h7FC00000, 4'b1000, 2);
      applyStimulus(0, 64'hFFC00000, 64'h00000000, 64'h7FC00000, 4'b0000, 2);
      applyStimulus(0, 64'h7F7FFFFF, 64'h40000000, 64'h7F800000, 4'b0101, 26);
      applyStimulus(0, 64'h7F7FFFFF, 64'h3F800001, 64'h7F800000, 4'b0101, 26);
      applyStimulus(0, 64'h7F000000, 64'h3F800000, 64'h7F000000, 4'b0000, 26);
      applyStimulus(0, 64'h00800000, 64'h3F000000, 64'h00000000, 4'b0011, 26);
      applyStimulus(0, 64'h00800000, 64'h3F800000, 64'h00800000, 4'b0000, 26);
      applyStimulus(0, 64'h80000000, 64'h3F800000, 64'h80000000, 4'b0000, 2);
      applyStimulus(0, 64'h00000001, 64'h40000000, 64'h00000000, 4'b0000, 2);

      // Four bits per cycle and double precision
      applyStimulus(1, 64'h3FC00000, 64'h40000000, 64'h40400000, 4'b0000, 8);
      applyStimulus(1, 64'h3F800001, 64'h3FC00000, 64'h3FC00002, 4'b0001, 8);
      applyStimulus(2, 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 4'b0000, 55);
      applyStimulus(2, 64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 4'b0001, 55);
      drainAll();

      // Backpressure: hold the result, a pending second operand must wait
      out_ready[0] = 1'b0;
      applyStimulus(0, 64'h3FC00000, 64'h40000000, 64'h40400000, 4'b0000, 26);
      begin
         int guard = 0;
         while (!out_valid[0] && guard < 100) begin @(negedge clk); guard++; end
         checkOutput("bp out_valid", 64'(out_valid[0]), 64'd1);
      end
      begin
         exp_t e;
         e.p = 64'hFF800000; e.f = 4'b0000; e.lat = 2;
         sb[0].push_back(e);
      end
      @(posedge clk); #1;
      a0 = 32'hFF800000; b0 = 32'h40000000; in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp hold product", prodW[0], 64'h40400000);
         checkOutput("bp hold flags", 64'(flagsW[0]), 64'h0);
         checkOutput("bp in_ready", 64'(in_ready[0]), 64'd0);
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp in_ready after release", 64'(in_ready[0]), 64'd1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      applyStimulus(0, 64'h3F800001, 64'h3FC00000, 64'h3FC00002, 4'b0001, 26);
      applyStimulus(0, 64'h7F800000, 64'h00000000, 64'h7FC00000, 4'b1000, 2);
      drainAll();

      // Reset in the middle of an iterative multiply abandons it
      issueRaw(0, 64'h3FC00000, 64'h40000000);
      repeat (11) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid reset product", prodW[0], 64'h0);
      checkOutput("mid reset flags", 64'(flagsW[0]), 64'h0);
      checkOutput("mid reset out_valid", 64'(out_valid[0]), 64'd0);
      checkOutput("mid reset in_ready", 64'(in_ready[0]), 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("post reset out_valid", 64'(out_valid[0]), 64'd0);
      checkOutput("post reset in_ready", 64'(in_ready[0]), 64'd1);
      applyStimulus(0, 64'h3FC00000, 64'h40000000, 64'h40400000, 4'b0000, 26);
      drainAll();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
